// File: rtl/nios2_debug_jtag_host.sv
// rtl/nios2_debug_jtag_host.sv - virtual-JTAG host that replays one IR+DR debug command
// Drives UIR/CDR/SDR/UDR/RTI from a free-running divided TCK; all outputs move on TCK falls.
module nios2_debug_jtag_host #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_HALF = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int DIV_W = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam int CNT_W = $clog2(SR_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PEND, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q;
    logic                tck_q;
    logic                tc, rise_ev, fall_ev;
    logic                accept, done;
    logic [IR_WIDTH-1:0] ir_q, ir_in_q, ir_out_q;
    logic [SR_WIDTH-1:0] shift_q, rsp_data_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                tdi_q;

    assign tc      = (div_q == DIV_W'(TCK_HALF - 1));
    assign rise_ev = tc & ~tck_q;
    assign fall_ev = tc & tck_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            tck_q <= 1'b0;
        end else if (tc) begin
            div_q <= '0;
            tck_q <= ~tck_q;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // The closing RTI fall doubles as an idle cycle so a waiting command is taken without a gap.
    assign done   = (state_q == S_RTI) && fall_ev;
    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cmd_valid) state_d = S_PEND;
            S_PEND: if (fall_ev)   state_d = S_UIR;
            S_UIR:  if (fall_ev)   state_d = S_CDR;
            S_CDR:  if (fall_ev)   state_d = S_SDR;
            S_SDR:  if (fall_ev && cnt_q == CNT_W'(SR_WIDTH)) state_d = S_UDR;
            S_UDR:  if (fall_ev)   state_d = S_RTI;
            S_RTI:  if (fall_ev)   state_d = cmd_valid ? S_PEND : S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q       <= '0;
            ir_in_q    <= '0;
            ir_out_q   <= '0;
            shift_q    <= '0;
            rsp_data_q <= '0;
            cnt_q      <= '0;
            tdi_q      <= 1'b0;
        end else begin
            if (accept) begin
                ir_q    <= cmd_ir;
                shift_q <= cmd_data;
                cnt_q   <= '0;
            end
            if (state_q == S_CDR && rise_ev) ir_out_q <= vji_ir_out;
            if (state_q == S_SDR && rise_ev) begin
                shift_q <= {vji_tdo, shift_q[SR_WIDTH-1:1]};
                cnt_q   <= cnt_q + CNT_W'(1);
            end
            if (fall_ev) begin
                if (state_q == S_PEND) ir_in_q <= ir_q;
                if (state_q == S_CDR || state_q == S_SDR) tdi_q <= shift_q[0];
            end
            if (done) rsp_data_q <= shift_q;
        end
    end

    always_comb begin
        cmd_ready  = (state_q == S_IDLE) || done;
        rsp_valid  = done;
        rsp_data   = done ? shift_q : rsp_data_q;
        rsp_ir_out = ir_out_q;
        vji_tck    = tck_q;
        vji_tdi    = tdi_q;
        vji_ir_in  = ir_in_q;
        vji_uir    = (state_q == S_UIR);
        vji_cdr    = (state_q == S_CDR);
        vji_sdr    = (state_q == S_SDR);
        vji_udr    = (state_q == S_UDR);
        vji_rti    = (state_q == S_IDLE) || (state_q == S_PEND) || (state_q == S_RTI);
    end

endmodule

// File: tb/tb_nios2_debug_jtag_host.sv
// tb/tb_nios2_debug_jtag_host.sv - scoreboard bench for nios2_debug_jtag_host
// Instance 0 uses TCK_HALF=2, instance 1 uses TCK_HALF=1; each has a loopback slave model.
module tb_nios2_debug_jtag_host;

    localparam int SRW = 38;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]     cmd_valid, cmd_ready, rsp_valid, tck, tdi, tdo, uir, cdr, sdr, udr, rti;
    logic [1:0]     cmd_ir [2];
    logic [SRW-1:0] cmd_data [2];
    logic [SRW-1:0] rsp_data [2];
    logic [1:0]     rsp_ir_out [2];
    logic [1:0]     ir_in [2];
    logic [1:0]     ir_out [2];
    logic [SRW-1:0] slv_pat [2];

    int checks = 0;
    int errors = 0;
    int rcyc;
    int sdr_rises [2];
    int udr_cnt [2];
    int rsp_cnt [2];
    int lat_last [2];
    bit b2b_seen [2];

    logic [SRW-1:0] q_rsp [2][$];
    logic [SRW-1:0] q_slv [2][$];
    logic [1:0]     q_ir  [2][$];
    logic [1:0]     q_iro [2][$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rcyc <= 0;
        else          rcyc <= rcyc + 1;
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int H = (g == 0) ? 2 : 1;
        localparam int P = 2 * H;

        nios2_debug_jtag_host #(.SR_WIDTH(SRW), .IR_WIDTH(2), .TCK_HALF(H)) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .cmd_valid  (cmd_valid[g]),
            .cmd_ready  (cmd_ready[g]),
            .cmd_ir     (cmd_ir[g]),
            .cmd_data   (cmd_data[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_data   (rsp_data[g]),
            .rsp_ir_out (rsp_ir_out[g]),
            .vji_tck    (tck[g]),
            .vji_tdi    (tdi[g]),
            .vji_tdo    (tdo[g]),
            .vji_ir_in  (ir_in[g]),
            .vji_ir_out (ir_out[g]),
            .vji_uir    (uir[g]),
            .vji_cdr    (cdr[g]),
            .vji_sdr    (sdr[g]),
            .vji_udr    (udr[g]),
            .vji_rti    (rti[g])
        );

        // Slave: captures its pattern in CDR, shifts TDI in / TDO out on TCK rise.
        logic [SRW-1:0] slv_sr = '0;
        always @(posedge tck[g]) begin
            if (cdr[g])      slv_sr <= slv_pat[g];
            else if (sdr[g]) slv_sr <= {tdi[g], slv_sr[SRW-1:1]};
        end
        assign tdo[g]    = slv_sr[0];
        assign ir_out[g] = {ir_in[g][0], ir_in[g][1]};

        initial begin : mon
            int acc_n, exp_lat, m, oh;
            logic p_tck, p_uir, p_udr, p_rv;
            acc_n = 0; exp_lat = 0; p_tck = 0; p_uir = 0; p_udr = 0; p_rv = 0;
            forever begin
                @(negedge clk);
                if (!reset_n) begin
                    p_tck = 0; p_uir = 0; p_udr = 0; p_rv = 0;
                    sdr_rises[g] = 0;
                end else begin
                    oh = int'(uir[g]) + int'(cdr[g]) + int'(sdr[g]) + int'(udr[g]) + int'(rti[g]);
                    check($sformatf("onehot%0d", g), oh, 1);
                    if (rsp_valid[g]) begin
                        rsp_cnt[g]++;
                        check($sformatf("rsp_pulse%0d", g), p_rv, 0);
                        check($sformatf("ready_at_rsp%0d", g), cmd_ready[g], 1);
                        check($sformatf("rsp_expected%0d", g), q_rsp[g].size() > 0, 1);
                        if (q_rsp[g].size() > 0) begin
                            check($sformatf("rsp_data%0d", g), rsp_data[g], q_rsp[g].pop_front());
                            check($sformatf("rsp_ir_out%0d", g), rsp_ir_out[g], q_iro[g].pop_front());
                            lat_last[g] = rcyc - acc_n;
                            check($sformatf("latency%0d", g), lat_last[g], exp_lat);
                        end
                        if (cmd_valid[g]) b2b_seen[g] = 1;
                    end
                    if (uir[g] && !p_uir) begin
                        sdr_rises[g] = 0;
                        check($sformatf("uir_expected%0d", g), q_ir[g].size() > 0, 1);
                        if (q_ir[g].size() > 0)
                            check($sformatf("uir_ir_in%0d", g), ir_in[g], q_ir[g].pop_front());
                    end
                    if (tck[g] && !p_tck && sdr[g]) sdr_rises[g]++;
                    if (udr[g] && !p_udr) begin
                        udr_cnt[g]++;
                        check($sformatf("sdr_periods%0d", g), sdr_rises[g], SRW);
                        check($sformatf("slave_expected%0d", g), q_slv[g].size() > 0, 1);
                        if (q_slv[g].size() > 0)
                            check($sformatf("slave_rx%0d", g), slv_sr, q_slv[g].pop_front());
                    end
                    if (cmd_valid[g] && cmd_ready[g]) begin
                        acc_n   = rcyc;
                        m       = rcyc % P;
                        exp_lat = ((m == P - 1) ? P : (P - 1 - m)) + (SRW + 4) * P;
                    end
                    p_tck = tck[g]; p_uir = uir[g]; p_udr = udr[g]; p_rv = rsp_valid[g];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int g, input logic [1:0] ir, input logic [SRW-1:0] data);
        int t;
        t = 0;
        q_ir[g].push_back(ir);
        q_slv[g].push_back(data);
        q_rsp[g].push_back(slv_pat[g]);
        q_iro[g].push_back({ir[0], ir[1]});
        cmd_valid[g] = 1'b1;
        cmd_ir[g]    = ir;
        cmd_data[g]  = data;
        while (!cmd_ready[g] && t < 1000) begin step(); t++; end
        check("accept_timeout", t < 1000, 1);
        step();
    endtask

    task automatic wait_done(input int g);
        int t;
        t = 0;
        while (q_rsp[g].size() != 0 && t < 3000) begin step(); t++; end
        check("rsp_timeout", q_rsp[g].size(), 0);
        repeat (3) step();
    endtask

    task automatic check_reset(input int g);
        check("rst_cmd_ready", cmd_ready[g], 1);
        check("rst_rti", rti[g], 1);
        check("rst_uir_cdr_sdr_udr", {uir[g], cdr[g], sdr[g], udr[g]}, 0);
        check("rst_tck", tck[g], 0);
        check("rst_tdi", tdi[g], 0);
        check("rst_ir_in", ir_in[g], 0);
        check("rst_rsp_valid", rsp_valid[g], 0);
        check("rst_rsp_data", rsp_data[g], 0);
        check("rst_rsp_ir_out", rsp_ir_out[g], 0);
    endtask

    task automatic wait_phase(input int p, input int ph);
        while (rcyc % p != ph) step();
    endtask

    initial begin
        int phs [4] = '{2, 1, 0, 3};
        int t, rc, uc;
        logic [63:0] r;
        cmd_valid = '0;
        for (int g = 0; g < 2; g++) begin
            cmd_ir[g] = '0; cmd_data[g] = '0; slv_pat[g] = '0;
            sdr_rises[g] = 0; udr_cnt[g] = 0; rsp_cnt[g] = 0; lat_last[g] = 0; b2b_seen[g] = 0;
        end
        #12;
        check_reset(0);
        check_reset(1);
        @(posedge clk); #3 reset_n = 1'b1;
        step();

        slv_pat[0] = 38'h2A_5A5A_5A5A;
        send(0, 2'b10, 38'h15_0F0F_F0F0);
        cmd_valid[0] = 1'b0;
        wait_done(0);
        check("loop_rsp_hold", rsp_data[0], 38'h2A_5A5A_5A5A);

        for (int i = 0; i < 4; i++) begin
            r = {$urandom(), $urandom()};
            slv_pat[0] = r[SRW-1:0];
            r = {$urandom(), $urandom()};
            wait_phase(4, phs[i]);
            send(0, 2'(i), r[SRW-1:0]);
            cmd_valid[0] = 1'b0;
            wait_done(0);
            check("lat_phase", lat_last[0], 169 + i);
        end

        slv_pat[0] = 38'h01_2345_6789;
        b2b_seen[0] = 0;
        send(0, 2'b00, 38'h2B_DEAD_BEEF);
        send(0, 2'b11, 38'h04_CAFE_F00D);
        check("b2b_second_accept_in_rsp", b2b_seen[0], 1);
        cmd_valid[0] = 1'b0;
        wait_done(0);

        slv_pat[0] = 38'h33_0000_FFFF;
        send(0, 2'b01, 38'h0A_AAAA_5555);
        cmd_valid[0] = 1'b0;
        t = 0;
        while (!(sdr[0] && sdr_rises[0] >= 10) && t < 500) begin step(); t++; end
        check("busy_reach_sdr", t < 500, 1);
        cmd_valid[0] = 1'b1; cmd_ir[0] = 2'b11; cmd_data[0] = 38'h3F_FFFF_FFFF;
        check("busy_ready_low", cmd_ready[0], 0);
        step();
        check("busy_ready_low2", cmd_ready[0], 0);
        cmd_valid[0] = 1'b0;
        wait_done(0);
        check("busy_rsp_count", rsp_cnt[0], 8);

        send(0, 2'b10, 38'h12_3456_789A);
        cmd_valid[0] = 1'b0;
        t = 0;
        while (sdr_rises[0] != 20 && t < 500) begin step(); t++; end
        check("abort_reach_bit20", t < 500, 1);
        rc = rsp_cnt[0]; uc = udr_cnt[0];
        #3 reset_n = 1'b0;
        #1;
        check_reset(0);
        for (int g = 0; g < 2; g++) begin
            q_rsp[g].delete(); q_slv[g].delete(); q_ir[g].delete(); q_iro[g].delete();
        end
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (200) step();
        check("abort_no_rsp", rsp_cnt[0], rc);
        check("abort_no_udr", udr_cnt[0], uc);
        slv_pat[0] = 38'h2A_5A5A_5A5A;
        send(0, 2'b01, 38'h15_0F0F_F0F0);
        cmd_valid[0] = 1'b0;
        wait_done(0);

        slv_pat[1] = 38'h2A_5A5A_5A5A;
        wait_phase(2, 0);
        send(1, 2'b10, 38'h15_0F0F_F0F0);
        cmd_valid[1] = 1'b0;
        wait_done(1);
        check("h1_lat_phase0", lat_last[1], 85);
        wait_phase(2, 1);
        send(1, 2'b01, 38'h2A_5A5A_5A5A);
        cmd_valid[1] = 1'b0;
        wait_done(1);
        check("h1_lat_phase1", lat_last[1], 86);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios2_debug_jtag_host.md
# nios2_debug_jtag_host

Host-side initiator for the Nios II debug slave's virtual-JTAG port. It accepts one debug command at a time: a 2-bit IR value plus a 38-bit data-register word. It replays the command onto the virtual-JTAG signal set (UIR, CDR, SDR, UDR, RTI) with a divided TCK, and returns the 38 bits captured from TDO. It sits in front of the debug slave's TCK-side logic, in place of the SLD hub, for simulation and on-chip self-test of the debug path.

## Interface
Parameters:
- SR_WIDTH, 38, data-register length in bits; sets the SDR shift count.
- IR_WIDTH, 2, instruction width.
- TCK_HALF, 2, TCK half-period in clk cycles; must be ≥1.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  reset, asynchronous and active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block is idle and can accept a command.
- cmd_ir  in  IR_WIDTH  instruction for this command.
- cmd_data  in  SR_WIDTH  word to shift into TDI, LSB first.
- rsp_valid  out  1  one-cycle pulse; the transaction is complete.
- rsp_data  out  SR_WIDTH  word captured from TDO; holds until the next rsp_valid.
- rsp_ir_out  out  IR_WIDTH  value of vji_ir_out captured during CDR.
- vji_tck  out  1  generated TCK.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_WIDTH  instruction to the slave.
- vji_ir_out  in  IR_WIDTH  instruction status from the slave.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1  virtual state indicators.

## Operation
- **TCK generation.** A divider counts 0..TCK_HALF-1 and toggles vji_tck at terminal count.
  - TCK runs freely from reset.
  - A "rise event" is the clk cycle in which vji_tck goes 0→1. A "fall event" is the cycle in which it goes 1→0.
- **Output updates.** All state outputs, vji_ir_in and vji_tdi change only on fall events, so they are stable at the slave's sampling edge. vji_tdo and vji_ir_out are sampled only on rise events.
- **States.**
  - IDLE: cmd_ready=1, vji_rti=1. A handshake (cmd_valid&&cmd_ready) latches cmd_ir into the IR register and cmd_data into the shift register, and moves to PEND. cmd_ready=0 from the next cycle.
  - PEND: waits for the next fall event, then goes to UIR.
  - UIR: entered with vji_ir_in=IR register and vji_uir=1. Lasts 1 TCK period, then goes to CDR.
  - CDR: vji_cdr=1. vji_ir_out is captured into rsp_ir_out on the rise event. Lasts 1 period; on leaving, vji_tdi=shift[0]. Goes to SDR.
  - SDR: vji_sdr=1 for exactly SR_WIDTH periods.
    - Each rise event: shift <= {vji_tdo, shift[SR_WIDTH-1:1]}, and the bit counter increments.
    - Each fall event: vji_tdi <= shift[0].
    - The state leaves on the fall event after the SR_WIDTH-th rise, going to UDR.
  - UDR: vji_udr=1 for 1 period, then RTI.
  - RTI: vji_rti=1 for 1 period. On the closing fall event: rsp_data <= shift, rsp_valid=1 for that single cycle, go to IDLE.
- **One-hot indicators.** Exactly one of uir/cdr/sdr/udr/rti is high at any time outside PEND. In PEND all five are 0 except rti, which stays 1 from IDLE.
- **Bit order.** cmd_data[0] is shifted first. The first TDO bit captured lands in rsp_data[0].
- cmd_valid while busy is ignored. No queueing.
- vji_ir_in holds its last value in IDLE.

## Timing
- **Reset values.**
  - State=IDLE, vji_tck=0, divider=0.
  - cmd_ready=1, vji_rti=1.
  - vji_uir/cdr/sdr/udr=0, vji_tdi=0, vji_ir_in=0.
  - rsp_valid=0, rsp_data=0, rsp_ir_out=0.
- **Period.** TCK period is P=2·TCK_HALF clk cycles.
- **Latency.** Transaction length is SR_WIDTH+4 periods after UIR entry. With defaults that is 42 periods, or 168 clk cycles.
  - Accept to rsp_valid = d + (SR_WIDTH+4)·P, where d ∈ [1,P] is the gap from the accept cycle to the next fall event (strictly later).
  - Defaults: 169..172 cycles.
- **Back-to-back.** cmd_ready rises in the rsp_valid cycle. The next command can be accepted in that same cycle.
- **Reset mid-transaction.** All state is cleared immediately and no rsp_valid is issued. vji_udr is never asserted for an aborted transaction.
- **TCK_HALF=1.** TCK toggles every clk cycle and rise and fall events alternate. Required behaviour is unchanged.

## Test plan
- **Loopback.** Defaults, vji_tdo driven by a 38-bit slave model that outputs 38'h2A_5A5A_5A5A, cmd_ir=2'b10, cmd_data=38'h15_0F0F_F0F0 → slave receives 38'h15_0F0F_F0F0; rsp_data=38'h2A_5A5A_5A5A; UIR showed ir_in=2'b10; exactly 38 SDR periods observed.
- **Latency and one-hot.** Accept at each of the 4 phase offsets relative to TCK → rsp_valid after 169, 170, 171 and 172 cycles respectively; a single-cycle pulse; the state indicators are one-hot throughout.
- **Back-to-back.** Commands with cmd_ir=2'b00 then 2'b11, cmd_valid held high → second accept occurs in the first rsp_valid cycle; the second UIR shows 2'b11.
- **Busy rejection.** Pulse cmd_valid with data 38'h3F_FFFF_FFFF mid-SDR → ignored; rsp_data reflects only the first command; cmd_ready=0 until rsp_valid.
- **Reset abort.** Deassert reset_n for 3 cycles at SDR bit 20 → all outputs return to reset values asynchronously; no udr and no rsp_valid; the next command completes normally.
- **TCK_HALF=1.** Rerun the loopback scenario → same data; accept-to-rsp latency is 85..86 cycles.
